seg7_stream_decoder: RTL and testbench

SEG7_STREAM_DECODER -- requirements
Module: seg7_stream_decoder

---
 rtl/seg7_dec_pkg.sv | 29 ++
 rtl/seg7_pattern_decode.sv | 28 ++
 rtl/seg7_stream_decoder.sv | 154 +++++++++++++++
 tb/tb_seg7_stream_decoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_dec_pkg.sv
// rtl/seg7_dec_pkg.sv - shared constants, tracker state enum and digit helper for the seg7 decoder
package seg7_dec_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] DIGIT_UNKNOWN = 4'hF;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_LOCKED = 2'd1,
        ST_ERROR  = 2'd2
    } track_state_t;

    // Successor digit in a 0..9 counting display.
    function automatic logic [3:0] next_digit(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational 7-segment pattern to BCD digit lookup
module seg7_pattern_decode
    import seg7_dec_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       known
);

    always_comb begin
        digit = DIGIT_UNKNOWN;
        known = 1'b1;
        case (pattern)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: known = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_stream_decoder.sv
// rtl/seg7_stream_decoder.sv - debounced 7-segment stream decoder with digit sequence tracker
// Optional wrap counter enabled by defining SEG7_DEC_WRAP_CNT_EN.
module seg7_stream_decoder
    import seg7_dec_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] segments_in,
    input  logic       seg_valid,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       seq_lock,
    output logic       seq_error,
    output logic [7:0] frame_count,
    output logic [7:0] wrap_count
);

    localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);

    logic [6:0]   candidate;
    logic [3:0]   stable_cnt;
    logic [6:0]   last_accepted;
    logic         accept;
    logic [3:0]   dec_digit;
    logic         dec_known;
    logic         in_seq;

    track_state_t state, state_next;
    logic [3:0]   prev_digit, prev_next;
    logic         prev_valid, prev_valid_next;
    logic         error_next;

    seg7_pattern_decode u_decode (
        .pattern (segments_in),
        .digit   (dec_digit),
        .known   (dec_known)
    );

    // Acceptance fires on the sample that brings the counter up to STABLE_MAX.
    assign accept = seg_valid
                 && (segments_in == candidate)
                 && (stable_cnt == STABLE_MAX - 4'd1)
                 && (segments_in != SEG_BLANK)
                 && (segments_in != last_accepted);

    assign in_seq   = dec_known && (dec_digit == next_digit(prev_digit));
    assign seq_lock = (state == ST_LOCKED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            candidate  <= SEG_BLANK;
            stable_cnt <= 4'd0;
        end else if (seg_valid) begin
            if (segments_in == candidate) begin
                if (stable_cnt < STABLE_MAX)
                    stable_cnt <= stable_cnt + 4'd1;
            end else begin
                candidate  <= segments_in;
                stable_cnt <= 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_accepted <= SEG_BLANK;
            digit         <= DIGIT_UNKNOWN;
            digit_valid   <= 1'b0;
            frame_count   <= 8'd0;
        end else begin
            digit_valid <= accept;
            if (accept) begin
                last_accepted <= segments_in;
                digit         <= dec_digit;
                if (frame_count != 8'hFF)
                    frame_count <= frame_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_SEARCH;
            prev_digit <= 4'd0;
            prev_valid <= 1'b0;
            seq_error  <= 1'b0;
        end else begin
            state      <= state_next;
            prev_digit <= prev_next;
            prev_valid <= prev_valid_next;
            seq_error  <= error_next;
        end
    end

    always_comb begin
        state_next      = state;
        prev_next       = prev_digit;
        prev_valid_next = prev_valid;
        error_next      = 1'b0;
        if (accept) begin
            case (state)
                ST_SEARCH: begin
                    if (dec_known) begin
                        prev_next       = dec_digit;
                        prev_valid_next = 1'b1;
                        if (prev_valid && in_seq)
                            state_next = ST_LOCKED;
                    end else begin
                        prev_valid_next = 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (in_seq) begin
                        prev_next = dec_digit;
                    end else begin
                        error_next = 1'b1;
                        state_next = ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    // Only a fresh 0 restarts tracking; everything else is ignored silently.
                    if (dec_known && dec_digit == 4'd0) begin
                        state_next      = ST_SEARCH;
                        prev_next       = 4'd0;
                        prev_valid_next = 1'b1;
                    end
                end
                default: state_next = ST_SEARCH;
            endcase
        end
    end

`ifdef SEG7_DEC_WRAP_CNT_EN
    logic       wrap_hit;
    logic [7:0] wrap_q;

    assign wrap_hit = accept && (state == ST_LOCKED) && in_seq
                   && (prev_digit == 4'd9) && (dec_digit == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wrap_q <= 8'd0;
        else if (wrap_hit && wrap_q != 8'hFF)
            wrap_q <= wrap_q + 8'd1;
    end

    assign wrap_count = wrap_q;
`else
    assign wrap_count = 8'd0;
`endif

endmodule

// File: tb/tb_seg7_stream_decoder.sv
// tb/tb_seg7_stream_decoder.sv - self-checking bench for seg7_stream_decoder
module tb_seg7_stream_decoder;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] segments_in = 7'h00;
    logic       seg_valid = 1'b0;
    logic [3:0] digit;
    logic       digit_valid;
    logic       seq_lock;
    logic       seq_error;
    logic [7:0] frame_count;
    logic [7:0] wrap_count;

    int total = 0;
    int bad = 0;

    seg7_stream_decoder #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .segments_in (segments_in),
        .seg_valid   (seg_valid),
        .digit       (digit),
        .digit_valid (digit_valid),
        .seq_lock    (seq_lock),
        .seq_error   (seq_error),
        .frame_count (frame_count),
        .wrap_count  (wrap_count)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model state: run of identical qualified samples plus a sequence tracker.
    int m_run_pat, m_run_len, m_last, m_mode, m_prev, m_prev_ok;
    int e_digit, e_dv, e_lock, e_err, e_fc, e_wrap;

    function automatic int decode(input int p);
        for (int k = 0; k < 10; k++)
            if (int'(seg_tab[k]) == p) return k;
        return 15;
    endfunction

    task automatic model_reset();
        m_run_pat = 0; m_run_len = 0; m_last = 0;
        m_mode = 0; m_prev = 0; m_prev_ok = 0;
        e_digit = 15; e_dv = 0; e_lock = 0; e_err = 0; e_fc = 0; e_wrap = 0;
    endtask

    task automatic model_track(input int d);
        bit known = (d != 15);
        bit succ  = known && (d == (m_prev + 1) % 10);
        if (m_mode == 0) begin
            if (known) begin
                if (m_prev_ok != 0 && succ) m_mode = 1;
                m_prev = d; m_prev_ok = 1;
            end else begin
                m_prev_ok = 0;
            end
        end else if (m_mode == 1) begin
            if (succ) begin
`ifdef SEG7_DEC_WRAP_CNT_EN
                if (m_prev == 9 && d == 0 && e_wrap < 255) e_wrap++;
`endif
                m_prev = d;
            end else begin
                e_err = 1; m_mode = 2;
            end
        end else if (d == 0) begin
            m_mode = 0; m_prev = 0; m_prev_ok = 1;
        end
        e_lock = (m_mode == 1);
    endtask

    task automatic model_tick(input bit v, input int p);
        e_dv = 0; e_err = 0;
        if (v) begin
            if (p == m_run_pat) m_run_len++;
            else begin m_run_pat = p; m_run_len = 1; end
            if (m_run_len == S && p != 0 && p != m_last) begin
                m_last = p;
                e_digit = decode(p);
                e_dv = 1;
                if (e_fc < 255) e_fc++;
                model_track(e_digit);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("digit", int'(digit), e_digit);
        chk("digit_valid", int'(digit_valid), e_dv);
        chk("seq_lock", int'(seq_lock), e_lock);
        chk("seq_error", int'(seq_error), e_err);
        chk("frame_count", int'(frame_count), e_fc);
        chk("wrap_count", int'(wrap_count), e_wrap);
    end

    task automatic step(input bit v, input logic [6:0] p);
        seg_valid = v;
        segments_in = p;
        @(posedge clk);
        model_tick(v, int'(p));
        @(negedge clk);
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        for (int k = 0; k < n; k++) step(1'b1, p);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("rst_digit", int'(digit), 15);
        chk("rst_fc", int'(frame_count), 0);
        chk("rst_lock", int'(seq_lock), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [6:0] pat;
        int nd;
        int n;
        model_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("init_digit", int'(digit), 15);
        chk("init_dv", int'(digit_valid), 0);

        // First acceptance after exactly S qualified samples.
        hold(7'h3F, 3);
        chk("pre_accept_dv", int'(digit_valid), 0);
        hold(7'h3F, 1);
        chk("first_dv", int'(digit_valid), 1);
        chk("first_digit", int'(digit), 0);
        chk("first_fc", int'(frame_count), 1);

        // Sequence lock on 0,1,2.
        hold(7'h06, S);
        chk("lock_after_1", int'(seq_lock), 1);
        hold(7'h5B, S);
        chk("lock_after_2", int'(seq_lock), 1);
        chk("no_err_2", int'(seq_error), 0);

        // Out-of-order digit while locked, then recovery through ERROR.
        hold(7'h4F, S);
        hold(7'h6D, S);
        chk("ooo_digit", int'(digit), 5);
        chk("ooo_err", int'(seq_error), 1);
        chk("ooo_lock", int'(seq_lock), 0);
        hold(7'h7F, S);
        chk("err_quiet", int'(seq_error), 0);
        chk("err_digit8", int'(digit), 8);
        hold(7'h3F, S);
        chk("recover_lock", int'(seq_lock), 0);
        hold(7'h06, S);
        chk("relock", int'(seq_lock), 1);

        // Glitch rejection and qualified-gap hold.
        do_reset();
        hold(7'h06, 3);
        hold(7'h5B, 1);
        hold(7'h06, S);
        chk("glitch_fc", int'(frame_count), 1);
        chk("glitch_digit", int'(digit), 1);
        hold(7'h66, 2);
        for (int k = 0; k < 3; k++) step(1'b0, 7'h7F);
        hold(7'h66, 2);
        chk("gap_fc", int'(frame_count), 2);
        chk("gap_digit", int'(digit), 4);

        // Wrap 7,8,9,0 then an unknown pattern while locked.
        do_reset();
        hold(7'h07, S);
        hold(7'h7F, S);
        hold(7'h6F, S);
        hold(7'h3F, S);
`ifdef SEG7_DEC_WRAP_CNT_EN
        chk("wrap_one", int'(wrap_count), 1);
`else
        chk("wrap_zero", int'(wrap_count), 0);
`endif
        chk("wrap_lock", int'(seq_lock), 1);
        hold(7'h22, S);
        chk("unk_digit", int'(digit), 15);
        chk("unk_err", int'(seq_error), 1);

        // Blank never accepted; same pattern not re-accepted.
        hold(7'h00, S + 2);
        hold(7'h22, S + 2);
        chk("blank_fc", int'(frame_count), 5);

        // Reset two samples into a stable run.
        do_reset();
        hold(7'h06, 2);
        do_reset();
        hold(7'h06, S - 1);
        chk("post_rst_wait", int'(digit_valid), 0);
        hold(7'h06, 1);
        chk("post_rst_dv", int'(digit_valid), 1);

        // Randomized runs, biased toward counting sequences.
        nd = 0;
        for (int r = 0; r < 150; r++) begin
            case ($urandom_range(0, 3))
                0, 1: begin pat = seg_tab[nd]; nd = (nd + 1) % 10; end
                2:    pat = seg_tab[$urandom_range(0, 9)];
                default: pat = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'(($urandom_range(1, 127)));
            endcase
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++)
                step($urandom_range(0, 99) < 85, pat);
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
